bits_to_bytes: RTL and testbench

Converts a flat `N_BYTES*8`-bit vector into a packed array of `N_BYTES` bytes, with byte `i` taken from bits `[8i+7:8i]` (little-endian, LSB-first). It sits between the bit-level compression/conversion stages and byte-oriented consumers. It provides:
- a zero-latency combinational view of the current input;
- a registered valid/ready stream path through a two-entry skid buffer, for use in pipelined datapaths.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/skid_buffer.sv | 81 ++++++++
 rtl/bits_to_bytes.sv | 56 +++++
 tb/tb_bits_to_bytes.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and the bit-to-byte mapping used by the converters.
// Byte i of the result is bits[8i +: 8]; pure rewiring, no arithmetic.
package conv_pkg;

    // Packages cannot be parameterised, so the mapping works on the widest
    // supported vector. Callers zero-extend and keep the low N_BYTES bytes.
    localparam int MAX_BYTES = 64;
    localparam int MAX_BITS  = MAX_BYTES * 8;

    typedef logic [MAX_BYTES-1:0][7:0] byte_arr_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic byte_arr_t bits_to_bytes_f(input logic [MAX_BITS-1:0] bits);
        byte_arr_t b;
        for (int i = 0; i < MAX_BYTES; i++) begin
            b[i] = bits[i*8 +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main output register plus one skid slot.
// Latency one cycle; in_ready is registered (skid empty), no path from out_ready.
module skid_buffer
    import conv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q;
    logic             accept;
    logic             drain;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != SKID_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid && rdy_q;
        drain   = (state_q != SKID_EMPTY) && out_ready;

        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                // A beat arriving while main drains replaces it: full throughput.
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a drain can move us.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/bits_to_bytes.sv
// Flat bit vector to little-endian byte array: combinational view plus a
// registered stream through a two-entry skid buffer (one-cycle latency).
module bits_to_bytes
    import conv_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_BYTES*8-1:0]    bits_i,
    output logic [N_BYTES-1:0][7:0] bytes_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [N_BYTES-1:0][7:0] out_bytes_o
);

    localparam int W = N_BYTES * 8;

    logic [MAX_BITS-1:0]     bits_ext;
    byte_arr_t               bytes_full;
    logic [N_BYTES-1:0][7:0] bytes_conv;
    logic [W-1:0]            out_flat;

    always_comb begin
        bits_ext        = '0;
        bits_ext[W-1:0] = bits_i;
    end

    assign bytes_full = bits_to_bytes_f(bits_ext);
    assign bytes_conv = bytes_full[N_BYTES-1:0];
    assign bytes_o    = bytes_conv;

    // Bytes above N_BYTES are constant zero and intentionally dropped.
    if (N_BYTES < MAX_BYTES) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^bytes_full[MAX_BYTES-1:N_BYTES];
    end

    skid_buffer #(
        .WIDTH(W)
    ) u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_data  (bytes_conv),
        .in_valid (in_valid_i),
        .in_ready (in_ready_o),
        .out_data (out_flat),
        .out_valid(out_valid_o),
        .out_ready(out_ready_i)
    );

    assign out_bytes_o = out_flat;

endmodule

// File: tb/tb_bits_to_bytes.sv
// Bench for bits_to_bytes: directed steps then random traffic against a queue model.
module tb_bits_to_bytes;

    logic            clk_i = 1'b0;
    logic            clk_en = 1'b0;
    logic            rst_ni = 1'b1;
    logic [31:0]     bits_i = '0;
    logic [3:0][7:0] bytes_o;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [3:0][7:0] out_bytes_o;

    int total = 0;
    int bad   = 0;

    // Reference: beats held in the block, oldest first.
    logic [31:0] mq[$];
    logic        m_rdy  = 1'b0;
    logic        m_zero = 1'b0;

    bits_to_bytes #(.N_BYTES(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bits_i     (bits_i),
        .bytes_o    (bytes_o),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_bytes_o(out_bytes_o)
    );

    always begin
        #5;
        if (clk_en) clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        logic [31:0] v;
        v = bits_i;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.byte%0d", tag, i), {24'd0, bytes_o[i]}, (v >> (8 * i)) & 32'hFF);
        end
    endtask

    // One clock: model sees the pre-edge inputs, outputs checked #1 after the edge.
    task automatic cycle(input string tag, input bit do_comb);
        logic [31:0] b;
        logic        acc, drn, r;
        #1;
        if (do_comb) chk_comb(tag);
        b   = bits_i;
        r   = rst_ni;
        acc = in_valid_i && m_rdy;
        drn = (mq.size() > 0) && out_ready_i;
        @(posedge clk_i);
        #1;
        if (!r) begin
            mq.delete();
            m_rdy  = 1'b0;
            m_zero = 1'b1;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(b);
                m_zero = 1'b0;
            end
            m_rdy = (mq.size() < 2);
        end
        chk({tag, ".in_ready"}, {31'd0, in_ready_o}, {31'd0, m_rdy});
        chk({tag, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0)
            chk({tag, ".out_bytes"}, out_bytes_o, mq[0]);
        else if (m_zero)
            chk({tag, ".out_bytes_zero"}, out_bytes_o, 32'd0);
    endtask

    initial begin
        // Combinational view with no clock running.
        bits_i = 32'h89ABCDEF;
        #1;
        chk("comb_89ABCDEF.b0", {24'd0, bytes_o[0]}, 32'hEF);
        chk("comb_89ABCDEF.b1", {24'd0, bytes_o[1]}, 32'hCD);
        chk("comb_89ABCDEF.b2", {24'd0, bytes_o[2]}, 32'hAB);
        chk("comb_89ABCDEF.b3", {24'd0, bytes_o[3]}, 32'h89);
        bits_i = 32'h0;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("comb_zero.b%0d", i), {24'd0, bytes_o[i]}, 32'h00);
        bits_i = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("comb_ones.b%0d", i), {24'd0, bytes_o[i]}, 32'hFF);
        bits_i = 32'h03020100;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("comb_index.b%0d", i), {24'd0, bytes_o[i]}, i);

        // Reset for two edges with a beat offered.
        clk_en      = 1'b1;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        bits_i      = 32'hDEADBEEF;
        cycle("reset1", 1'b0);
        cycle("reset2", 1'b0);
        chk("reset.out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset.out_bytes", out_bytes_o, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready_o}, 32'd0);
        rst_ni     = 1'b1;
        in_valid_i = 1'b0;
        cycle("release", 1'b0);
        chk("release.in_ready", {31'd0, in_ready_o}, 32'd1);

        // Full-throughput streaming of beats 1..4.
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid_i = 1'b1;
            bits_i     = k;
            cycle($sformatf("stream%0d", k), 1'b1);
            chk($sformatf("stream%0d.byte0", k), {24'd0, out_bytes_o[0]}, k);
            chk($sformatf("stream%0d.in_ready_held", k), {31'd0, in_ready_o}, 32'd1);
        end
        in_valid_i = 1'b0;
        cycle("stream_tail", 1'b0);
        cycle("stream_idle", 1'b0);

        // Backpressure: three beats offered while downstream stalls.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        bits_i = 32'hA000_0001; cycle("bp_a", 1'b0);
        bits_i = 32'hB000_0002; cycle("bp_b", 1'b0);
        chk("bp.in_ready_low", {31'd0, in_ready_o}, 32'd0);
        bits_i = 32'hC000_0003; cycle("bp_c_blocked", 1'b0);
        cycle("bp_stall", 1'b0);
        chk("bp.hold_first", out_bytes_o, 32'hA000_0001);
        out_ready_i = 1'b1;
        cycle("bp_drain_a", 1'b0);
        chk("bp.second_out", out_bytes_o, 32'hB000_0002);
        cycle("bp_accept_c", 1'b0);
        chk("bp.third_out", out_bytes_o, 32'hC000_0003);
        in_valid_i = 1'b0;
        cycle("bp_drain_c", 1'b0);
        chk("bp.empty", {31'd0, out_valid_o}, 32'd0);

        // Reset while both entries are full.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        bits_i = 32'h1111_1111; cycle("fill1", 1'b0);
        bits_i = 32'h2222_2222; cycle("fill2", 1'b0);
        rst_ni = 1'b0;
        cycle("rst_full", 1'b0);
        chk("rst_full.out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_full.out_bytes", out_bytes_o, 32'd0);
        rst_ni     = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        cycle("rst_full_release", 1'b0);
        chk("rst_full.in_ready", {31'd0, in_ready_o}, 32'd1);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            bits_i      = $urandom;
            rst_ni      = ($urandom_range(0, 60) != 0);
            cycle("rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
